// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - decode constants, control bundle and select-width helper
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // rs field value that selects "move to coprocessor 0" under OP_COP0
    localparam logic [4:0] COP0_MT = 5'h04;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_LUI = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        alu_op_e   alu_op;
        logic      alu_src_imm;
        logic      is_link;
        logic      is_jump;
        logic      is_branch;
        logic      branch_ne;
        logic      mem_read;
        logic      mem_write;
        mem_size_e mem_size;
        logic      mem_to_reg;
        logic      reg_write;
        logic      c0_write;
        logic      illegal;
    } ctrl_t;

    function automatic int sel_width(input int nfwd);
        return $clog2(nfwd + 1);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - two async read ports, one sync write port, write-through
module regfile_2r1w #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd,
    input  logic [REG_AW-1:0] ra_s,
    input  logic [REG_AW-1:0] ra_t,
    output logic [XLEN-1:0]   rd_s,
    output logic [XLEN-1:0]   rd_t
);

    logic [XLEN-1:0] mem [2**REG_AW];

    always_ff @(posedge clk) begin
        if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    // Index 0 is hardwired to zero; a pending write to the read index is bypassed
    assign rd_s = (ra_s == '0) ? '0 : ((we && wa == ra_s) ? wd : mem[ra_s]);
    assign rd_t = (ra_t == '0) ? '0 : ((we && wa == ra_t) ? wd : mem[ra_t]);

endmodule

// File: rtl/decode_unit.sv
// rtl/decode_unit.sv - instruction decode stage with operand forwarding and load-use stall
module decode_unit
    import id_pkg::*;
#(
    parameter int  XLEN   = 32,
    parameter int  NFWD   = 3,
    parameter int  REG_AW = 5,
    localparam int SW     = sel_width(NFWD)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [31:0]        instruction,
    input  logic [XLEN-1:0]    pc_next,
    output logic [REG_AW-1:0]  rs_probe,
    output logic [REG_AW-1:0]  rt_probe,
    input  logic [SW-1:0]      ctrl_rs,
    input  logic [SW-1:0]      ctrl_rt,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic               wb_we,
    input  logic [REG_AW-1:0]  wb_reg,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               ex_mem_read,
    input  logic [REG_AW-1:0]  ex_reg_t,
    output logic               stall_req,
    output logic               out_valid,
    output logic [3:0]         alu_op,
    output logic               alu_src_imm,
    output logic               is_link,
    output logic               is_jump,
    output logic               is_branch,
    output logic               branch_ne,
    output logic               mem_read,
    output logic               mem_write,
    output logic [1:0]         mem_size,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               c0_write,
    output logic               illegal,
    output logic [REG_AW-1:0]  reg_d,
    output logic [XLEN-1:0]    data_s,
    output logic [XLEN-1:0]    data_t,
    output logic [XLEN-1:0]    imm,
    output logic [XLEN-1:0]    pc_jump,
    output logic [XLEN-1:0]    pc_next_out
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rs_f;
    logic [REG_AW-1:0] rd_idx;
    logic [XLEN-1:0]   rf_s, rf_t;
    logic [XLEN-1:0]   sel_s, sel_t;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   pc_jump_d;
    logic [REG_AW-1:0] dst;
    logic              legal;
    logic              rt_used;
    logic              load_ok;
    ctrl_t             dec;
    ctrl_t             bubble;
    ctrl_t             ctrl_q;

    assign opcode   = instruction[31:26];
    assign funct    = instruction[5:0];
    assign rs_f     = instruction[25:21];
    assign rs_probe = REG_AW'(instruction[25:21]);
    assign rt_probe = REG_AW'(instruction[20:16]);
    assign rd_idx   = REG_AW'(instruction[15:11]);

    regfile_2r1w #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_rf (
        .clk  (clk),
        .we   (wb_we),
        .wa   (wb_reg),
        .wd   (wb_data),
        .ra_s (rs_probe),
        .ra_t (rt_probe),
        .rd_s (rf_s),
        .rd_t (rf_t)
    );

    // Selects outside 1..NFWD fall back to the register file; r0 stays zero even if forwarded
    always_comb begin
        sel_s = rf_s;
        sel_t = rf_t;
        for (int k = 1; k <= NFWD; k++) begin
            if (ctrl_rs == SW'(k)) sel_s = fwd_data[(k-1)*XLEN +: XLEN];
            if (ctrl_rt == SW'(k)) sel_t = fwd_data[(k-1)*XLEN +: XLEN];
        end
        if (rs_probe == '0) sel_s = '0;
        if (rt_probe == '0) sel_t = '0;
    end

    always_comb begin
        dec     = '0;
        legal   = 1'b1;
        rt_used = 1'b0;
        dst     = rt_probe;
        case (opcode)
            OP_RTYPE: begin
                dst           = rd_idx;
                rt_used       = 1'b1;
                dec.reg_write = 1'b1;
                case (funct)
                    FN_ADD: dec.alu_op = ALU_ADD;
                    FN_SUB: dec.alu_op = ALU_SUB;
                    FN_AND: dec.alu_op = ALU_AND;
                    FN_OR:  dec.alu_op = ALU_OR;
                    FN_SLT: dec.alu_op = ALU_SLT;
                    FN_SLL: dec.alu_op = ALU_SLL;
                    FN_SRL: dec.alu_op = ALU_SRL;
                    FN_JR: begin
                        dec.is_jump   = 1'b1;
                        dec.reg_write = 1'b0;
                        rt_used       = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                case (opcode)
                    OP_ANDI: dec.alu_op = ALU_AND;
                    OP_ORI:  dec.alu_op = ALU_OR;
                    OP_SLTI: dec.alu_op = ALU_SLT;
                    OP_LUI:  dec.alu_op = ALU_LUI;
                    default: dec.alu_op = ALU_ADD;
                endcase
            end
            OP_LW, OP_LB: begin
                dec.alu_src_imm = 1'b1;
                dec.mem_read    = 1'b1;
                dec.mem_to_reg  = 1'b1;
                dec.reg_write   = 1'b1;
                dec.mem_size    = (opcode == OP_LW) ? MEM_WORD : MEM_BYTE;
            end
            OP_SW, OP_SB: begin
                rt_used         = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.mem_write   = 1'b1;
                dec.mem_size    = (opcode == OP_SW) ? MEM_WORD : MEM_BYTE;
            end
            OP_BEQ, OP_BNE: begin
                rt_used       = 1'b1;
                dec.alu_op    = ALU_SUB;
                dec.is_branch = 1'b1;
                dec.branch_ne = (opcode == OP_BNE);
            end
            OP_J: dec.is_jump = 1'b1;
            OP_JAL: begin
                dec.is_jump   = 1'b1;
                dec.is_link   = 1'b1;
                dec.reg_write = 1'b1;
                dst           = REG_AW'(31);
            end
            OP_COP0: begin
                if (rs_f == COP0_MT) begin
                    rt_used      = 1'b1;
                    dec.c0_write = 1'b1;
                    dst          = rd_idx;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        imm_ext = {{(XLEN-16){instruction[15]}}, instruction[15:0]};
        if (opcode == OP_ANDI || opcode == OP_ORI) begin
            imm_ext = {{(XLEN-16){1'b0}}, instruction[15:0]};
        end
        pc_jump_d = '0;
        if (opcode == OP_J || opcode == OP_JAL) begin
            pc_jump_d = {pc_next[XLEN-1:28], instruction[25:0], 2'b00};
        end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
            pc_jump_d = pc_next + (imm_ext << 2);
        end else if (opcode == OP_RTYPE && funct == FN_JR) begin
            pc_jump_d = sel_s;
        end
    end

    assign stall_req = in_valid & ex_mem_read & (ex_reg_t != '0) &
                       ((ex_reg_t == rs_probe) | (rt_used & (ex_reg_t == rt_probe)));

    assign load_ok = in_valid & ~stall_req & legal;

    // A bubble only reports illegal when it replaced a real, unstalled instruction
    always_comb begin
        bubble         = '0;
        bubble.illegal = in_valid & ~stall_req & ~legal;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            out_valid   <= 1'b0;
            ctrl_q      <= '0;
            reg_d       <= '0;
            data_s      <= '0;
            data_t      <= '0;
            imm         <= '0;
            pc_jump     <= '0;
            pc_next_out <= '0;
        end else if (we) begin
            out_valid   <= load_ok;
            ctrl_q      <= load_ok ? dec : bubble;
            reg_d       <= load_ok ? dst : '0;
            data_s      <= load_ok ? sel_s : '0;
            data_t      <= load_ok ? sel_t : '0;
            imm         <= load_ok ? imm_ext : '0;
            pc_jump     <= load_ok ? pc_jump_d : '0;
            pc_next_out <= load_ok ? pc_next : '0;
        end
    end

    assign alu_op      = ctrl_q.alu_op;
    assign alu_src_imm = ctrl_q.alu_src_imm;
    assign is_link     = ctrl_q.is_link;
    assign is_jump     = ctrl_q.is_jump;
    assign is_branch   = ctrl_q.is_branch;
    assign branch_ne   = ctrl_q.branch_ne;
    assign mem_read    = ctrl_q.mem_read;
    assign mem_write   = ctrl_q.mem_write;
    assign mem_size    = ctrl_q.mem_size;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign reg_write   = ctrl_q.reg_write;
    assign c0_write    = ctrl_q.c0_write;
    assign illegal     = ctrl_q.illegal;

endmodule
